alu_reservation_station: RTL and testbench

//  Reservation station directly upstream of the arithmetic unit. Holds dispatched ALU ops
//  (OP, OP-IMM, LUI, AUIPC, JAL, JALR) until both source operands are valid.

---
 rtl/alu_reservation_station_pkg.sv | 22 ++
 rtl/alu_reservation_station_age_matrix.sv | 58 +++++
 rtl/alu_reservation_station.sv | 177 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared constants for the ALU reservation station: datapath width, default
// geometry and the opcode set that dispatch routes to this station.
package alu_reservation_station_pkg;

    localparam int XLEN          = 32;
    localparam int TAG_W_DEFAULT = 4;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // True for every opcode that dispatch steers into this station.
    function automatic logic is_alu_opcode(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
               (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/alu_reservation_station_age_matrix.sv
// Age matrix: older_q[i][j]=1 means entry j is older than entry i.
// Grants the request whose row has no older requester.
module alu_reservation_station_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    // Next matrix: a new entry sees every resident as older and nobody as younger.
    always_comb begin
        older_d = older_q;
        if (flush_i) begin
            older_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free_i[i]) begin
                    older_d[i] = '0;
                end else if (alloc_i[i]) begin
                    older_d[i] = valid_i;
                end else begin
                    older_d[i] = older_d[i];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[i][j] = older_d[i][j] & ~alloc_i[j];
                end
            end
        end
    end

    // Matrix register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    // Oldest-first grant.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = req_i[i] & ~|(req_i & older_q[i]);
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops the CDB, and issues the oldest ready op as a registered bundle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             dispatch_valid_i,
    output logic             dispatch_ready_o,
    input  logic [XLEN-1:0]  dispatch_pc_i,
    input  logic [XLEN-1:0]  dispatch_inst_i,
    input  logic [TAG_W-1:0] dispatch_tag_i,
    input  logic             rs1_ready_i,
    input  logic [XLEN-1:0]  rs1_value_i,
    input  logic [TAG_W-1:0] rs1_tag_i,
    input  logic             rs2_ready_i,
    input  logic [XLEN-1:0]  rs2_value_i,
    input  logic [TAG_W-1:0] rs2_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]  cdb_value_i,
    output logic             alu_request_o,
    output logic [XLEN-1:0]  issue_pc_o,
    output logic [XLEN-1:0]  issue_inst_o,
    output logic [XLEN-1:0]  issue_rs1_value_o,
    output logic [XLEN-1:0]  issue_rs2_value_o,
    output logic [TAG_W-1:0] issue_tag_o
);

    logic [DEPTH-1:0] valid_q, valid_d, rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [XLEN-1:0]  pc_q [DEPTH], pc_d [DEPTH], inst_q [DEPTH], inst_d [DEPTH];
    logic [XLEN-1:0]  rs1_val_q [DEPTH], rs1_val_d [DEPTH], rs2_val_q [DEPTH], rs2_val_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH], tag_d [DEPTH];
    logic [TAG_W-1:0] rs1_tag_q [DEPTH], rs1_tag_d [DEPTH], rs2_tag_q [DEPTH], rs2_tag_d [DEPTH];

    logic [DEPTH-1:0] free_oh_s, alloc_s, free_s, req_s, grant_s, wake1_s, wake2_s;
    logic             do_alloc_s, issue_fire_s, byp1_s, byp2_s;

    logic             alu_request_q, alu_request_d;
    logic [XLEN-1:0]  issue_pc_q, issue_pc_d, issue_inst_q, issue_inst_d;
    logic [XLEN-1:0]  issue_rs1_q, issue_rs1_d, issue_rs2_q, issue_rs2_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;

    assign dispatch_ready_o = ~reset_i & ~&valid_q;
    assign do_alloc_s       = dispatch_valid_i & dispatch_ready_o & ~flush_i;
    assign alloc_s          = do_alloc_s ? free_oh_s : '0;
    assign req_s            = valid_q & rs1_rdy_q & rs2_rdy_q;
    assign issue_fire_s     = |grant_s & ~flush_i;
    assign free_s           = issue_fire_s ? grant_s : '0;
    assign byp1_s           = cdb_valid_i & (cdb_tag_i == rs1_tag_i);
    assign byp2_s           = cdb_valid_i & (cdb_tag_i == rs2_tag_i);

    // Lowest-index free slot and per-entry CDB tag matches.
    always_comb begin
        free_oh_s = '0;
        wake1_s   = '0;
        wake2_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_oh_s[i] = ~valid_q[i] & (free_oh_s == '0);
            wake1_s[i]   = valid_q[i] & ~rs1_rdy_q[i] & cdb_valid_i & (rs1_tag_q[i] == cdb_tag_i);
            wake2_s[i]   = valid_q[i] & ~rs2_rdy_q[i] & cdb_valid_i & (rs2_tag_q[i] == cdb_tag_i);
        end
    end

    // Entry next state: allocate, free on issue, or capture CDB wakeups.
    always_comb begin
        valid_d = valid_q;   rs1_rdy_d = rs1_rdy_q; rs2_rdy_d = rs2_rdy_q;
        pc_d    = pc_q;      inst_d    = inst_q;    tag_d     = tag_q;
        rs1_val_d = rs1_val_q; rs2_val_d = rs2_val_q;
        rs1_tag_d = rs1_tag_q; rs2_tag_d = rs2_tag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_s[i]) begin
                valid_d[i]   = 1'b1;
                pc_d[i]      = dispatch_pc_i;
                inst_d[i]    = dispatch_inst_i;
                tag_d[i]     = dispatch_tag_i;
                rs1_rdy_d[i] = rs1_ready_i | byp1_s;
                rs1_val_d[i] = rs1_ready_i ? rs1_value_i : cdb_value_i;
                rs1_tag_d[i] = rs1_tag_i;
                rs2_rdy_d[i] = rs2_ready_i | byp2_s;
                rs2_val_d[i] = rs2_ready_i ? rs2_value_i : cdb_value_i;
                rs2_tag_d[i] = rs2_tag_i;
            end else if (free_s[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                rs1_rdy_d[i] = rs1_rdy_q[i] | wake1_s[i];
                rs1_val_d[i] = wake1_s[i] ? cdb_value_i : rs1_val_q[i];
                rs2_rdy_d[i] = rs2_rdy_q[i] | wake2_s[i];
                rs2_val_d[i] = wake2_s[i] ? cdb_value_i : rs2_val_q[i];
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Entry storage; only the valid/ready bits need a defined reset value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
        end
        pc_q      <= pc_d;      inst_q    <= inst_d;    tag_q     <= tag_d;
        rs1_val_q <= rs1_val_d; rs2_val_q <= rs2_val_d;
        rs1_tag_q <= rs1_tag_d; rs2_tag_q <= rs2_tag_d;
    end

    alu_reservation_station_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .alloc_i (alloc_s),
        .free_i  (free_s),
        .valid_i (valid_q),
        .req_i   (req_s),
        .grant_o (grant_s)
    );

    // Issue mux; data holds its last value when nothing is selected.
    always_comb begin
        alu_request_d = issue_fire_s;
        issue_pc_d    = issue_pc_q;
        issue_inst_d  = issue_inst_q;
        issue_rs1_d   = issue_rs1_q;
        issue_rs2_d   = issue_rs2_q;
        issue_tag_d   = issue_tag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (free_s[i]) begin
                issue_pc_d   = pc_q[i];
                issue_inst_d = inst_q[i];
                issue_rs1_d  = rs1_val_q[i];
                issue_rs2_d  = rs2_val_q[i];
                issue_tag_d  = tag_q[i];
            end else begin
                issue_tag_d = issue_tag_d;
            end
        end
    end

    // Issue registers feeding the ALU directly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alu_request_q <= 1'b0;
            issue_pc_q    <= '0;
            issue_inst_q  <= '0;
            issue_rs1_q   <= '0;
            issue_rs2_q   <= '0;
            issue_tag_q   <= '0;
        end else begin
            alu_request_q <= alu_request_d;
            issue_pc_q    <= issue_pc_d;
            issue_inst_q  <= issue_inst_d;
            issue_rs1_q   <= issue_rs1_d;
            issue_rs2_q   <= issue_rs2_d;
            issue_tag_q   <= issue_tag_d;
        end
    end

    assign alu_request_o     = alu_request_q;
    assign issue_pc_o        = issue_pc_q;
    assign issue_inst_o      = issue_inst_q;
    assign issue_rs1_value_o = issue_rs1_q;
    assign issue_rs2_value_o = issue_rs2_q;
    assign issue_tag_o       = issue_tag_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: a scoreboard queue of
// expected issues, popped whenever the DUT raises alu_request_o.
module tb_alu_reservation_station;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, dispatch_valid_i, dispatch_ready_o;
    logic [31:0] dispatch_pc_i, dispatch_inst_i, rs1_value_i, rs2_value_i, cdb_value_i;
    logic [3:0]  dispatch_tag_i, rs1_tag_i, rs2_tag_i, cdb_tag_i, issue_tag_o;
    logic        rs1_ready_i, rs2_ready_i, cdb_valid_i, alu_request_o;
    logic [31:0] issue_pc_o, issue_inst_o, issue_rs1_value_o, issue_rs2_value_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
        .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
        .dispatch_tag_i(dispatch_tag_i),
        .rs1_ready_i(rs1_ready_i), .rs1_value_i(rs1_value_i), .rs1_tag_i(rs1_tag_i),
        .rs2_ready_i(rs2_ready_i), .rs2_value_i(rs2_value_i), .rs2_tag_i(rs2_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
        .alu_request_o(alu_request_o), .issue_pc_o(issue_pc_o), .issue_inst_o(issue_inst_o),
        .issue_rs1_value_o(issue_rs1_value_o), .issue_rs2_value_o(issue_rs2_value_o),
        .issue_tag_o(issue_tag_o)
    );

    // Scoreboard: every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (alu_request_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue got tag=%0d pc=%h", issue_tag_o, issue_pc_o);
            end else begin
                mon_e = sb_q.pop_front();
                if ({issue_tag_o, issue_pc_o, issue_inst_o, issue_rs1_value_o, issue_rs2_value_o} !==
                    {mon_e.tag, mon_e.pc, mon_e.inst, mon_e.rs1, mon_e.rs2}) begin
                    failures++;
                    $display("FAIL issue_bundle got tag=%0d pc=%h inst=%h rs1=%h rs2=%h exp tag=%0d pc=%h inst=%h rs1=%h rs2=%h",
                             issue_tag_o, issue_pc_o, issue_inst_o, issue_rs1_value_o, issue_rs2_value_o,
                             mon_e.tag, mon_e.pc, mon_e.inst, mon_e.rs1, mon_e.rs2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        e.tag = tag; e.pc = pc; e.inst = inst; e.rs1 = rs1; e.rs2 = rs2;
        sb_q.push_back(e);
    endtask

    // Drives one dispatch for a single cycle.
    task automatic dispatch(input logic [3:0] tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                            input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
        dispatch_valid_i = 1'b1;
        dispatch_tag_i = tag; dispatch_pc_i = pc; dispatch_inst_i = inst;
        rs1_ready_i = r1rdy; rs1_value_i = r1val; rs1_tag_i = r1tag;
        rs2_ready_i = r2rdy; rs2_value_i = r2val; rs2_tag_i = r2tag;
        tick();
        dispatch_valid_i = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid_i = 1'b1; cdb_tag_i = tag; cdb_value_i = val;
        tick();
        cdb_valid_i = 1'b0;
    endtask

    task automatic expect_req(input string name, input logic exp_req, input logic [3:0] exp_tag);
        checks++;
        if (alu_request_o !== exp_req || (exp_req && issue_tag_o !== exp_tag)) begin
            failures++;
            $display("FAIL %s got req=%b tag=%0d exp req=%b tag=%0d", name, alu_request_o, issue_tag_o, exp_req, exp_tag);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        checks++;
        if ({alu_request_o, dispatch_ready_o, issue_pc_o, issue_inst_o, issue_rs1_value_o,
             issue_rs2_value_o, issue_tag_o} !== 134'd0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b rdy=%b tag=%0d pc=%h exp all zero",
                     alu_request_o, dispatch_ready_o, issue_tag_o, issue_pc_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (dispatch_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got %b exp 1", dispatch_ready_o);
        end
    endtask

    task automatic test_basic_issue();
        push(4'd3, 32'h0000_1000, 32'h0020_81B3, 32'd5, 32'd7);
        dispatch(4'd3, 32'h0000_1000, 32'h0020_81B3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        expect_req("basic_select_cycle", 1'b0, 4'd0);
        tick();
        expect_req("basic_issue", 1'b1, 4'd3);
        tick();
        expect_req("basic_idle", 1'b0, 4'd0);
    endtask

    task automatic test_cdb_wakeup();
        push(4'd4, 32'h0000_2000, 32'h0041_0233, 32'd11, 32'h1234);
        dispatch(4'd4, 32'h0000_2000, 32'h0041_0233, 1'b1, 32'd11, 4'd0, 1'b0, 32'd0, 4'd9);
        tick();
        expect_req("wake_blocked", 1'b0, 4'd0);
        cdb(4'd9, 32'h1234);
        expect_req("wake_not_yet", 1'b0, 4'd0);
        tick();
        expect_req("wake_issue", 1'b1, 4'd4);
        checks++;
        if (issue_rs2_value_o !== 32'h1234) begin
            failures++;
            $display("FAIL wake_rs2 got %h exp %h", issue_rs2_value_o, 32'h1234);
        end
    endtask

    task automatic test_dispatch_bypass();
        push(4'd5, 32'h0000_3000, 32'h0051_02B3, 32'hAA, 32'd2);
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd6; cdb_value_i = 32'hAA;
        dispatch(4'd5, 32'h0000_3000, 32'h0051_02B3, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0);
        cdb_valid_i = 1'b0;
        tick();
        expect_req("bypass_issue", 1'b1, 4'd5);
        checks++;
        if (issue_rs1_value_o !== 32'hAA) begin
            failures++;
            $display("FAIL bypass_rs1 got %h exp %h", issue_rs1_value_o, 32'hAA);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            dispatch(4'(i + 1), 32'h4000 + 32'(i * 4), 32'h0000_0033 + 32'(i), 1'b0, 32'd0, 4'd10,
                     1'b1, 32'(100 + i), 4'd0);
        end
        checks++;
        if (dispatch_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got %b exp 0", dispatch_ready_o);
        end
        dispatch_valid_i = 1'b1; dispatch_tag_i = 4'd15; rs1_ready_i = 1'b1; rs2_ready_i = 1'b1;
        tick(); tick();
        dispatch_valid_i = 1'b0;
        checks++;
        if (dispatch_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_still got %b exp 0", dispatch_ready_o);
        end
        for (int i = 0; i < 4; i++) push(4'(i + 1), 32'h4000 + 32'(i * 4), 32'h0000_0033 + 32'(i), 32'h55, 32'(100 + i));
        cdb(4'd10, 32'h55);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_req("full_drain_order", 1'b1, 4'(i + 1));
        end
        tick();
        expect_req("full_drain_done", 1'b0, 4'd0);
    endtask

    task automatic test_age_order();
        dispatch(4'd1, 32'h5000, 32'h1, 1'b0, 32'd0, 4'd11, 1'b1, 32'd1, 4'd0);
        dispatch(4'd2, 32'h5004, 32'h2, 1'b0, 32'd0, 4'd12, 1'b1, 32'd2, 4'd0);
        dispatch(4'd3, 32'h5008, 32'h3, 1'b0, 32'd0, 4'd13, 1'b1, 32'd3, 4'd0);
        push(4'd1, 32'h5000, 32'h1, 32'hA1, 32'd1);
        cdb(4'd11, 32'hA1);
        tick();
        expect_req("age_first", 1'b1, 4'd1);
        // Slot 0 is free again, so this younger op lands below the older slot 2.
        dispatch(4'd4, 32'h500C, 32'h4, 1'b0, 32'd0, 4'd13, 1'b1, 32'd4, 4'd0);
        push(4'd3, 32'h5008, 32'h3, 32'hC3, 32'd3);
        push(4'd4, 32'h500C, 32'h4, 32'hC3, 32'd4);
        cdb(4'd13, 32'hC3);
        tick();
        expect_req("age_slot2_first", 1'b1, 4'd3);
        tick();
        expect_req("age_slot0_second", 1'b1, 4'd4);
        push(4'd2, 32'h5004, 32'h2, 32'hB2, 32'd2);
        cdb(4'd12, 32'hB2);
        tick();
        expect_req("age_last", 1'b1, 4'd2);
        tick();
    endtask

    task automatic test_flush();
        dispatch(4'd5, 32'h6000, 32'h5, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0);
        dispatch(4'd6, 32'h6004, 32'h6, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0);
        dispatch(4'd7, 32'h6008, 32'h7, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);
        flush_i = 1'b1;
        dispatch(4'd8, 32'h600C, 32'h8, 1'b1, 32'd8, 4'd0, 1'b1, 32'd8, 4'd0);
        flush_i = 1'b0;
        expect_req("flush_no_issue", 1'b0, 4'd0);
        checks++;
        if (dispatch_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready got %b exp 1", dispatch_ready_o);
        end
        cdb(4'd14, 32'hEE);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_req("flush_stays_idle", 1'b0, 4'd0);
        end
    endtask

    task automatic test_reset_mid();
        push(4'd9, 32'h7000, 32'h9, 32'd1, 32'd2);
        dispatch(4'd9, 32'h7000, 32'h9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        tick();
        expect_req("pre_reset_issue", 1'b1, 4'd9);
        dispatch(4'd10, 32'h7004, 32'hA, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0);
        reset_i = 1'b1;
        #1;
        checks++;
        if (dispatch_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_reset got %b exp 0", dispatch_ready_o);
        end
        tick();
        checks++;
        if ({alu_request_o, issue_tag_o, issue_pc_o, issue_rs1_value_o} !== 69'd0) begin
            failures++;
            $display("FAIL mid_reset_zero got req=%b tag=%0d pc=%h rs1=%h exp 0",
                     alu_request_o, issue_tag_o, issue_pc_o, issue_rs1_value_o);
        end
        reset_i = 1'b0;
        tick(); tick();
        expect_req("post_reset_idle", 1'b0, 4'd0);
    endtask

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; dispatch_valid_i = 1'b0;
        dispatch_pc_i = '0; dispatch_inst_i = '0; dispatch_tag_i = '0;
        rs1_ready_i = 1'b0; rs1_value_i = '0; rs1_tag_i = '0;
        rs2_ready_i = 1'b0; rs2_value_i = '0; rs2_tag_i = '0;
        cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_value_i = '0;
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_dispatch_bypass();
        test_full();
        test_age_order();
        test_flush();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
